// File: rtl/anita3_trig_pkg.sv
// Shared types and defaults for the ANITA-3 LAB buffer scheduler.
// Buffer indices are 2 bits wide because exactly four LAB buffers (A..D) exist.
package anita3_trig_pkg;

    localparam int NBUF      = 4;
    localparam int BUF_IDX_W = 2;

    localparam int DIG_LEN_DEF = 4;
    localparam int HOLDOFF_DEF = 16;
    localparam int DEAD_W_DEF  = 16;

    typedef logic [BUF_IDX_W-1:0] buf_idx_t;
    typedef logic [NBUF-1:0]      buf_mask_t;

    // Scheduler phases.
    // IDLE waits for a trigger.
    // ISSUE holds the digitize strobe high.
    // HOLDOFF is a quiet gap before the next trigger may be accepted.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } sched_state_t;

    // Used to size the shared ISSUE/HOLDOFF down-counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_free_picker.sv
// Round-robin free-buffer picker.
// The search starts at the buffer after rr_ptr_i and wraps modulo NBUF.
// The held mask is rotated so the search start lands at bit 0.
// A priority encoder then finds the lowest free bit.
// Adding the start back to that offset undoes the rotation.
module rr_free_picker
    import anita3_trig_pkg::*;
(
    input  buf_mask_t held_i,
    input  buf_idx_t  rr_ptr_i,
    output logic      found_o,
    output buf_idx_t  idx_o,
    output buf_mask_t onehot_o
);

    buf_idx_t               searchStart;
    logic [2*NBUF-1:0]      heldTwice;
    buf_mask_t              freeRot;
    buf_idx_t               freeOffset;

    // Rotate, priority-encode the first free slot, and map it back to a real index.
    // The 2-bit index arithmetic wraps modulo 4 on its own.
    always_comb begin
        searchStart = rr_ptr_i + buf_idx_t'(1);
        heldTwice   = {held_i, held_i};
        freeRot     = ~heldTwice[searchStart +: NBUF];
        found_o     = |freeRot;
        freeOffset  = '0;
        for (int k = NBUF - 1; k >= 0; k--) begin
            if (freeRot[k]) begin
                freeOffset = buf_idx_t'(k);
            end
        end
        idx_o    = searchStart + freeOffset;
        onehot_o = '0;
        if (found_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/anita3_buffer_scheduler.sv
// ANITA-3 LAB buffer scheduler.
// Accepts triggers, allocates one of four digitization buffers round-robin,
// and strobes the event generator for DIG_LEN cycles.
// After the strobe it enforces a HOLDOFF gap before the next trigger.
// It tracks which buffers stay held until readout clears them.
// It also accumulates deadtime, i.e. cycles in which a trigger would be refused.
module anita3_buffer_scheduler
    import anita3_trig_pkg::*;
#(
    parameter int DIG_LEN = DIG_LEN_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF,
    parameter int DEAD_W  = DEAD_W_DEF
) (
    input  logic              clk125_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              trig_i,
    input  logic [3:0]        trig_source_i,
    input  logic [3:0]        clear_i,
    input  logic              deadtime_clr_i,
    output logic              digitize_o,
    output logic [1:0]        digitize_buffer_o,
    output logic [3:0]        digitize_source_o,
    output logic [3:0]        buffer_status_o,
    output logic              full_o,
    output logic              trig_lost_o,
    output logic [DEAD_W-1:0] deadtime_o
);

    // One counter times both ISSUE and HOLDOFF.
    // It is sized for whichever phase is longer.
    localparam int TIMER_W = $clog2(max_int(DIG_LEN, HOLDOFF));

    sched_state_t        state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    buf_mask_t           held_q, held_d;
    buf_idx_t            rr_ptr_q, rr_ptr_d;
    buf_idx_t            buf_q, buf_d;
    logic [3:0]          src_q, src_d;
    logic                trig_lost_q, trig_lost_d;
    logic [DEAD_W-1:0]   deadtime_q, deadtime_d;

    logic                accept;
    logic                alloc;
    logic                heldFull;
    logic                pickFound;
    buf_idx_t            pickIdx;
    buf_mask_t           pickOnehot;

    assign heldFull = &held_q;

    // The search uses the registered held mask.
    // A clear arriving in the same cycle only takes effect for the next trigger.
    rr_free_picker u_picker (
        .held_i   (held_q),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pickFound),
        .idx_o    (pickIdx),
        .onehot_o (pickOnehot)
    );

    // Next-state logic for the phase sequencer.
    // It also produces the accept decision, which only holds in IDLE.
    // Once a sequence has started it always runs to completion,
    // even if enable_i drops part-way through.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept = enable_i & ~heldFull;
                if (trig_i && accept) begin
                    state_d = ST_ISSUE;
                    timer_d = TIMER_W'(DIG_LEN - 1);
                end
            end
            ST_ISSUE: begin
                if (timer_q == '0) begin
                    state_d = ST_HOLDOFF;
                    timer_d = TIMER_W'(HOLDOFF - 1);
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Next-state logic for allocation.
    // Readout clears and the new allocation are merged into held.
    // The picker never returns a held buffer, so the clear and allocation terms cannot collide.
    // The trigger source is latched together with the chosen buffer.
    always_comb begin
        alloc    = trig_i & accept & pickFound;
        held_d   = held_q & ~clear_i;
        rr_ptr_d = rr_ptr_q;
        buf_d    = buf_q;
        src_d    = src_q;
        if (alloc) begin
            held_d   = held_d | pickOnehot;
            rr_ptr_d = pickIdx;
            buf_d    = pickIdx;
            src_d    = trig_source_i;
        end
    end

    // Next-state logic for the trigger-lost flag and the deadtime counter.
    // Deadtime counts every cycle in which a trigger would be refused.
    // It saturates at all-ones rather than wrapping.
    // A clear request takes priority over counting in the same cycle.
    always_comb begin
        trig_lost_d = trig_i & ~accept;
        deadtime_d  = deadtime_q;
        if (deadtime_clr_i) begin
            deadtime_d = '0;
        end else if (!accept && !(&deadtime_q)) begin
            deadtime_d = deadtime_q + DEAD_W'(1);
        end
    end

    // Register all state.
    // rr_ptr resets to 3 so the first search starts at buffer 0.
    always_ff @(posedge clk125_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            held_q      <= '0;
            rr_ptr_q    <= buf_idx_t'(NBUF - 1);
            buf_q       <= '0;
            src_q       <= '0;
            trig_lost_q <= 1'b0;
            deadtime_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            held_q      <= held_d;
            rr_ptr_q    <= rr_ptr_d;
            buf_q       <= buf_d;
            src_q       <= src_d;
            trig_lost_q <= trig_lost_d;
            deadtime_q  <= deadtime_d;
        end
    end

    // The strobe is derived from the state register.
    // A reset therefore drops it immediately, without waiting for a clock edge.
    assign digitize_o        = (state_q == ST_ISSUE);
    assign digitize_buffer_o = buf_q;
    assign digitize_source_o = src_q;
    assign buffer_status_o   = held_q;
    assign full_o            = heldFull;
    assign trig_lost_o       = trig_lost_q;
    assign deadtime_o        = deadtime_q;

endmodule

// File: tb/tb_anita3_buffer_scheduler.sv
// Testbench for the ANITA-3 LAB buffer scheduler.
// The reference model tracks time since the last accepted trigger and a held-buffer mask.
// It predicts every output after every clock edge.
module tb_anita3_buffer_scheduler;

    localparam int DW       = 10;
    localparam int DEAD_MAX = (1 << DW) - 1;
    localparam int DIG      = 4;
    localparam int SPACING  = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          trg;
    logic          dclr;
    logic [3:0]    src;
    logic [3:0]    clr;
    logic          dig;
    logic [1:0]    dbuf;
    logic [3:0]    dsrc;
    logic [3:0]    status;
    logic          full;
    logic          lost;
    logic [DW-1:0] dead;

    int errors = 0;
    int checks = 0;

    logic [3:0] mHeld;
    int         mRr;
    int         mNow;
    int         mNextAllowed;
    int         mAcceptAt;
    logic [1:0] mBuf;
    logic [3:0] mSrc;
    logic       mLost;
    int         mDead;

    always #5 clk = ~clk;

    anita3_buffer_scheduler #(
        .DIG_LEN (DIG),
        .HOLDOFF (16),
        .DEAD_W  (DW)
    ) dut (
        .clk125_i          (clk),
        .rst_i             (rst),
        .enable_i          (en),
        .trig_i            (trg),
        .trig_source_i     (src),
        .clear_i           (clr),
        .deadtime_clr_i    (dclr),
        .digitize_o        (dig),
        .digitize_buffer_o (dbuf),
        .digitize_source_o (dsrc),
        .buffer_status_o   (status),
        .full_o            (full),
        .trig_lost_o       (lost),
        .deadtime_o        (dead)
    );

    // Compare one observed value against the model and record the outcome.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Return the model to its power-on state.
    task automatic modelReset();
        mHeld        = 4'b0000;
        mRr          = 3;
        mNow         = 0;
        mNextAllowed = 0;
        mAcceptAt    = -100;
        mBuf         = 2'd0;
        mSrc         = 4'd0;
        mLost        = 1'b0;
        mDead        = 0;
    endtask

    // Advance the model by one cycle.
    // The inputs are those present in front of the clock edge.
    task automatic modelStep(input logic e, input logic t, input logic [3:0] s,
                             input logic [3:0] c, input logic d);
        logic acc;
        int   sel;
        acc   = (mNow >= mNextAllowed) && e && (mHeld != 4'hF);
        mLost = t && !acc;
        if (d) mDead = 0;
        else if (!acc && mDead < DEAD_MAX) mDead = mDead + 1;
        sel = -1;
        if (t && acc) begin
            for (int i = 1; i <= 4; i++) begin
                if (sel < 0 && !mHeld[(mRr + i) % 4]) sel = (mRr + i) % 4;
            end
        end
        mHeld = mHeld & ~c;
        if (sel >= 0) begin
            mHeld[sel]   = 1'b1;
            mRr          = sel;
            mBuf         = 2'(sel);
            mSrc         = s;
            mAcceptAt    = mNow;
            mNextAllowed = mNow + SPACING;
        end
        mNow = mNow + 1;
    endtask

    // Compare every DUT output against the model.
    // Buffer and source are only compared while the strobe is expected high.
    task automatic checkOutput(input string tag);
        logic expDig;
        expDig = ((mNow - mAcceptAt) >= 1) && ((mNow - mAcceptAt) <= DIG);
        check($sformatf("%s_dig", tag), 32'(dig), 32'(expDig));
        if (expDig) begin
            check($sformatf("%s_buf", tag), 32'(dbuf), 32'(mBuf));
            check($sformatf("%s_src", tag), 32'(dsrc), 32'(mSrc));
        end
        check($sformatf("%s_status", tag), 32'(status), 32'(mHeld));
        check($sformatf("%s_full", tag), 32'(full), 32'(&mHeld));
        check($sformatf("%s_lost", tag), 32'(lost), 32'(mLost));
        check($sformatf("%s_dead", tag), 32'(dead), 32'(mDead));
    endtask

    // Drive one cycle of inputs, clock the DUT and model, then check just after the edge.
    task automatic applyStimulus(input string tag, input logic e, input logic t,
                                 input logic [3:0] s, input logic [3:0] c, input logic d);
        en   = e;
        trg  = t;
        src  = s;
        clr  = c;
        dclr = d;
        modelStep(e, t, s, c, d);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Run n cycles with no trigger, no clear and no deadtime clear.
    task automatic idle(input string tag, input int n, input logic e);
        for (int i = 0; i < n; i++) applyStimulus(tag, e, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    // Directed scenarios first, then randomized traffic.
    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        trg  = 1'b0;
        src  = 4'h0;
        clr  = 4'h0;
        dclr = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dig", 32'(dig), 32'd0);
        check("rst_buf", 32'(dbuf), 32'd0);
        check("rst_src", 32'(dsrc), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        check("rst_dead", 32'(dead), 32'd0);
        #1 rst = 1'b0;

        // First trigger goes to buffer 0 and latches source 5.
        idle("t1_pre", 2, 1'b1);
        applyStimulus("t1_trig", 1'b1, 1'b1, 4'h5, 4'h0, 1'b0);
        check("t1_buf0", 32'(dbuf), 32'd0);
        check("t1_src5", 32'(dsrc), 32'd5);
        check("t1_stat", 32'(status), 32'b0001);
        idle("t1_hold", 20, 1'b1);

        // Three more triggers fill buffers 1..3; a fifth one is refused.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus("t2_trig", 1'b1, 1'b1, 4'(k + 8), 4'h0, 1'b0);
            check("t2_bufk", 32'(dbuf), 32'(k));
            idle("t2_hold", 20, 1'b1);
        end
        check("t2_stat", 32'(status), 32'b1111);
        check("t2_full", 32'(full), 32'd1);
        applyStimulus("t2_fifth", 1'b1, 1'b1, 4'hA, 4'h0, 1'b0);
        check("t2_lost", 32'(lost), 32'd1);
        check("t2_nodig", 32'(dig), 32'd0);

        // Release buffer 2 alone; the search wraps from buffer 0 and lands on 2.
        applyStimulus("t3_clr", 1'b1, 1'b0, 4'h0, 4'b0100, 1'b0);
        check("t3_notfull", 32'(full), 32'd0);
        applyStimulus("t3_trig", 1'b1, 1'b1, 4'h3, 4'h0, 1'b0);
        check("t3_buf2", 32'(dbuf), 32'd2);
        check("t3_stat", 32'(status), 32'b1111);
        idle("t3_hold", 20, 1'b1);

        // A trigger during ISSUE is dropped; a trigger exactly 21 cycles on is accepted.
        applyStimulus("t4_clr", 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        applyStimulus("t4_trig", 1'b1, 1'b1, 4'h7, 4'h0, 1'b0);
        check("t4_buf3", 32'(dbuf), 32'd3);
        idle("t4_gap", 2, 1'b1);
        applyStimulus("t4_busy", 1'b1, 1'b1, 4'h1, 4'h0, 1'b0);
        check("t4_lost", 32'(lost), 32'd1);
        check("t4_stat", 32'(status), 32'b1000);
        idle("t4_wait", 17, 1'b1);
        applyStimulus("t4_trig21", 1'b1, 1'b1, 4'h2, 4'h0, 1'b0);
        check("t4_dig21", 32'(dig), 32'd1);
        check("t4_buf0", 32'(dbuf), 32'd0);
        idle("t4_hold", 20, 1'b1);

        // Deadtime saturates while disabled; a clear wins over counting.
        idle("t5_sat", DEAD_MAX + 20, 1'b0);
        check("t5_satval", 32'(dead), 32'(DEAD_MAX));
        applyStimulus("t5_clr", 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
        check("t5_zero", 32'(dead), 32'd0);
        applyStimulus("t5_inc", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        check("t5_one", 32'(dead), 32'd1);

        // Asynchronous reset in the middle of ISSUE.
        applyStimulus("t6_trig", 1'b1, 1'b1, 4'hC, 4'hF, 1'b0);
        idle("t6_issue", 1, 1'b1);
        check("t6_digpre", 32'(dig), 32'd1);
        rst = 1'b1;
        trg = 1'b0;
        modelReset();
        #1;
        check("t6_dig", 32'(dig), 32'd0);
        check("t6_stat", 32'(status), 32'd0);
        check("t6_dead", 32'(dead), 32'd0);
        #1 rst = 1'b0;
        idle("t6_post", 1, 1'b1);
        applyStimulus("t6_trig2", 1'b1, 1'b1, 4'h6, 4'h0, 1'b0);
        check("t6_buf0", 32'(dbuf), 32'd0);

        // Randomized traffic: sparse triggers, occasional clears, disables and deadtime clears.
        for (int i = 0; i < 600; i++) begin
            applyStimulus("rnd",
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 3) == 0),
                          4'($urandom),
                          ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0,
                          ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
